// File: rtl/load_store_unit_if.sv
// Handshake bundle for load_store_unit: execute-side operation offer,
// writeback result, and the request/grant/response data-memory port.
//   master : the load/store unit view (drives ex_ready, wb_*, mem_req/we/addr/be/wdata)
//   slave  : the pipeline/memory view (drives ex_*, dm_*, alu_data_out, rd_in, mem_gnt/rvalid/rdata)
interface load_store_unit_if #(
    parameter int unsigned XLEN = 64
);
    localparam int unsigned NB = XLEN / 8;

    // execute side
    logic            ex_valid;
    logic            ex_ready;
    logic            dm_read_enable;
    logic            dm_write_enable;
    logic [2:0]      dm_funct3;
    logic [XLEN-1:0] alu_data_out;
    logic [XLEN-1:0] dm_write_data;
    logic [4:0]      rd_in;

    // writeback side
    logic            wb_valid;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      wb_rd;
    logic            wb_exc;
    logic [1:0]      wb_exc_cause;

    // data-memory port
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [NB-1:0]   mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        input  ex_valid, dm_read_enable, dm_write_enable, dm_funct3,
               alu_data_out, dm_write_data, rd_in,
               mem_gnt, mem_rvalid, mem_rdata,
        output ex_ready, wb_valid, wb_data, wb_rd, wb_exc, wb_exc_cause,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport slave (
        output ex_valid, dm_read_enable, dm_write_enable, dm_funct3,
               alu_data_out, dm_write_data, rd_in,
               mem_gnt, mem_rvalid, mem_rdata,
        input  ex_ready, wb_valid, wb_data, wb_rd, wb_exc, wb_exc_cause,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and writeback.
// Accepts one load/store/bypass operation at a time, issues it on a
// request/grant/response data-memory port with byte enables and lane-shifted
// store data, and returns a registered one-cycle writeback pulse with
// sign/zero-extended load data or an exception cause.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - load_store_unit_if.master (execute offer, writeback result, memory port)
//
// Parameters:
//   XLEN           - data/address width, 32 or 64
//   TIMEOUT_CYCLES - cycles allowed in REQ plus RESP before an access fault (>= 2)
//
// Configuration macro:
//   LSU_ALIGN_CHECK_EN - when defined, misaligned accesses raise a
//                        misalignment exception instead of being rounded down.
module load_store_unit #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.master  bus
);
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_LD_MIS = 2'd1;
    localparam logic [1:0] CAUSE_ST_MIS = 2'd2;
    localparam logic [1:0] CAUSE_FAULT  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic             store_q;

    // decode of the offered operation
    logic [1:0]       dec_size;
    logic [OFF_W-1:0] dec_off_raw;
    logic [OFF_W-1:0] dec_size_mask;
    logic [OFF_W-1:0] dec_off;
    logic [NB-1:0]    dec_be;
    logic [XLEN-1:0]  dec_wdata;
    logic             dec_illegal;
    logic             dec_align_exc;

    // load result formatting
    logic [XLEN-1:0]  ld_shifted;
    logic [6:0]       ld_bits;
    logic             ld_sign;
    logic [XLEN-1:0]  ld_data;

    logic             tmo_hit;

    assign bus.ex_ready = (state == IDLE) && !rst;
    assign tmo_hit      = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Operation decode: size, lane offset, byte enables, shifted store data, legality.
    always_comb begin
        dec_size      = bus.dm_funct3[1:0];
        dec_off_raw   = bus.alu_data_out[OFF_W-1:0];
        dec_size_mask = OFF_W'((4'd1 << dec_size) - 4'd1);
        // Rounding down is harmless when the alignment check is on: a
        // misaligned access never reaches the memory port in that build.
        dec_off       = dec_off_raw & ~dec_size_mask;
        dec_be        = NB'((16'd1 << (5'd1 << dec_size)) - 16'd1) << dec_off;
        dec_wdata     = bus.dm_write_data << {dec_off, 3'b000};
        dec_illegal   = (bus.dm_funct3 == 3'b111)
                     || ((XLEN == 32) && ((bus.dm_funct3 == 3'b011) || (bus.dm_funct3 == 3'b110)))
                     || (bus.dm_write_enable && bus.dm_funct3[2]);
`ifdef LSU_ALIGN_CHECK_EN
        dec_align_exc = |(dec_off_raw & dec_size_mask);
`else
        dec_align_exc = 1'b0;
`endif
    end

    // Load data: move the addressed lane to bit 0, then extend above the access size.
    always_comb begin
        ld_shifted = bus.mem_rdata >> {off_q, 3'b000};
        ld_bits    = 7'd8 << size_q;
        ld_sign    = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (7'(i) == ld_bits - 7'd1) begin
                ld_sign = ld_shifted[i] & ~uns_q;
            end
        end
        for (int i = 0; i < XLEN; i++) begin
            ld_data[i] = (7'(i) < ld_bits) ? ld_shifted[i] : ld_sign;
        end
    end

    // Control FSM with registered writeback and memory-request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            off_q            <= '0;
            size_q           <= '0;
            uns_q            <= 1'b0;
            store_q          <= 1'b0;
            bus.wb_valid     <= 1'b0;
            bus.wb_data      <= '0;
            bus.wb_rd        <= '0;
            bus.wb_exc       <= 1'b0;
            bus.wb_exc_cause <= CAUSE_NONE;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_be       <= '0;
            bus.mem_wdata    <= '0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid) begin
                        bus.wb_rd <= bus.rd_in;
                        tmo_cnt   <= '0;
                        if (!bus.dm_read_enable && !bus.dm_write_enable) begin
                            bus.wb_valid     <= 1'b1;
                            bus.wb_data      <= bus.alu_data_out;
                            bus.wb_exc       <= 1'b0;
                            bus.wb_exc_cause <= CAUSE_NONE;
                        end else if ((bus.dm_read_enable && bus.dm_write_enable) || dec_illegal) begin
                            bus.wb_valid     <= 1'b1;
                            bus.wb_data      <= '0;
                            bus.wb_exc       <= 1'b1;
                            bus.wb_exc_cause <= CAUSE_FAULT;
                        end else if (dec_align_exc) begin
                            bus.wb_valid     <= 1'b1;
                            bus.wb_data      <= '0;
                            bus.wb_exc       <= 1'b1;
                            bus.wb_exc_cause <= bus.dm_write_enable ? CAUSE_ST_MIS : CAUSE_LD_MIS;
                        end else begin
                            state         <= REQ;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.dm_write_enable;
                            bus.mem_addr  <= {bus.alu_data_out[XLEN-1:OFF_W], {OFF_W{1'b0}}};
                            bus.mem_be    <= dec_be;
                            bus.mem_wdata <= dec_wdata;
                            off_q         <= dec_off;
                            size_q        <= dec_size;
                            uns_q         <= bus.dm_funct3[2];
                            store_q       <= bus.dm_write_enable;
                        end
                    end
                end
                REQ: begin
                    if (tmo_hit) begin
                        state            <= IDLE;
                        bus.mem_req      <= 1'b0;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_data      <= '0;
                        bus.wb_exc       <= 1'b1;
                        bus.wb_exc_cause <= CAUSE_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                        if (bus.mem_gnt) begin
                            state       <= RESP;
                            bus.mem_req <= 1'b0;
                        end
                    end
                end
                RESP: begin
                    // A response arriving on the timeout cycle still completes normally.
                    if (bus.mem_rvalid) begin
                        state            <= IDLE;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_data      <= store_q ? '0 : ld_data;
                        bus.wb_exc       <= 1'b0;
                        bus.wb_exc_cause <= CAUSE_NONE;
                    end else if (tmo_hit) begin
                        state            <= IDLE;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_data      <= '0;
                        bus.wb_exc       <= 1'b1;
                        bus.wb_exc_cause <= CAUSE_FAULT;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (XLEN=64, TIMEOUT_CYCLES=8).
// Expected writebacks and memory requests are queued when an operation is
// offered and popped when the DUT produces a writeback or the memory model
// grants a request. Outputs are sampled 1 time unit after each rising edge.
module tb_load_store_unit;
    localparam int unsigned XLEN = 64;
    localparam int unsigned TMO  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(XLEN)) bus ();

    load_store_unit #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        exc;
        logic [1:0]  cause;
    } wb_exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  be;
        logic        we;
        logic [63:0] wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];

    int n_vec, n_err;
    int cyc, acc_cyc, wb_cyc, wb_cnt, req_cyc_cnt;
    int rsp_gnt_wait, rsp_rv_dly, rsp_phase, rsp_cnt;
    bit rsp_never_gnt, rsp_stray;
    logic [63:0] rsp_rdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void exp_wb(input logic [63:0] d, input logic [4:0] rd,
                                   input logic exc, input logic [1:0] cause);
        wb_exp_t e;
        e.data = d; e.rd = rd; e.exc = exc; e.cause = cause;
        wb_q.push_back(e);
    endfunction

    function automatic void exp_req(input logic [63:0] a, input logic [7:0] be,
                                    input logic we, input logic [63:0] wd);
        req_exp_t e;
        e.addr = a; e.be = be; e.we = we; e.wdata = wd;
        req_q.push_back(e);
    endfunction

    // Reference load: gather bytes by lane, then extend.
    function automatic logic [63:0] load_model(input logic [2:0] f3, input logic [2:0] off,
                                               input logic [63:0] rdata);
        int n;
        logic [63:0] r;
        n = 1 << f3[1:0];
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = rdata[8*(int'(off) + k) +: 8];
        if (!f3[2] && r[8*n-1]) for (int b = 8*n; b < 64; b++) r[b] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] be_model(input logic [2:0] f3, input logic [2:0] off);
        logic [7:0] b;
        b = '0;
        for (int k = 0; k < (1 << f3[1:0]); k++) b[int'(off) + k] = 1'b1;
        return b;
    endfunction

    task automatic monitor();
        if (bus.mem_req === 1'b1) req_cyc_cnt++;
        if (bus.wb_valid === 1'b1) begin
            wb_cnt++;
            wb_cyc = cyc;
            if (wb_q.size() == 0) check("wb_spurious", 64'd1, 64'd0);
            else begin
                wb_exp_t e;
                e = wb_q.pop_front();
                check("wb_data", bus.wb_data, e.data);
                check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
                check("wb_exc", 64'(bus.wb_exc), 64'(e.exc));
                check("wb_cause", 64'(bus.wb_exc_cause), 64'(e.cause));
            end
        end
    endtask

    task automatic grant_check();
        if (req_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else begin
            req_exp_t e;
            e = req_q.pop_front();
            check("req_addr", bus.mem_addr, e.addr);
            check("req_be", 64'(bus.mem_be), 64'(e.be));
            check("req_we", 64'(bus.mem_we), 64'(e.we));
            if (e.we) check("req_wdata", bus.mem_wdata, e.wdata);
        end
    endtask

    // Memory model: grant after rsp_gnt_wait request cycles, respond rsp_rv_dly cycles later.
    task automatic respond();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        if (rst) begin
            rsp_phase = 0;
            rsp_cnt   = 0;
        end else if (rsp_stray) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = '1;
            rsp_stray      = 1'b0;
        end else if (rsp_phase == 0) begin
            if (bus.mem_req === 1'b1 && !rsp_never_gnt) begin
                if (rsp_cnt >= rsp_gnt_wait) begin
                    bus.mem_gnt = 1'b1;
                    grant_check();
                    rsp_phase = 1;
                    rsp_cnt   = 0;
                end else rsp_cnt++;
            end else rsp_cnt = 0;
        end else begin
            rsp_cnt++;
            if (rsp_cnt >= rsp_rv_dly) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rsp_rdata;
                rsp_phase = 0;
                rsp_cnt   = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        respond();
    endtask

    task automatic issue(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        check("ex_ready_offer", 64'(bus.ex_ready), 64'd1);
        bus.ex_valid        = 1'b1;
        bus.dm_read_enable  = rd_en;
        bus.dm_write_enable = wr_en;
        bus.dm_funct3       = f3;
        bus.alu_data_out    = addr;
        bus.dm_write_data   = wd;
        bus.rd_in           = rd;
        cycle();
        acc_cyc             = cyc;
        bus.ex_valid        = 1'b0;
        bus.dm_read_enable  = 1'b0;
        bus.dm_write_enable = 1'b0;
        bus.alu_data_out    = 64'hFFFF_0000_FFFF_0000;
        bus.dm_write_data   = 64'h0F0F_0F0F_0F0F_0F0F;
    endtask

    function automatic bit drained();
        return (wb_q.size() == 0) && (rsp_phase == 0) && (bus.ex_ready === 1'b1);
    endfunction

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (drained()) break;
            cycle();
        end
        if (!drained()) check("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_lat(input string tag, input int exp);
        check(tag, 64'(wb_cyc - acc_cyc), 64'(exp));
    endtask

    initial begin
        int r0, w0, busy, n;
        logic [63:0] a, d;
        logic [2:0] f3;

        n_vec = 0; n_err = 0; cyc = 0; wb_cnt = 0; req_cyc_cnt = 0; wb_cyc = 0; acc_cyc = 0;
        rsp_gnt_wait = 0; rsp_rv_dly = 1; rsp_phase = 0; rsp_cnt = 0;
        rsp_never_gnt = 1'b0; rsp_stray = 1'b0; rsp_rdata = '0;
        bus.ex_valid = 1'b0; bus.dm_read_enable = 1'b0; bus.dm_write_enable = 1'b0;
        bus.dm_funct3 = 3'b000; bus.alu_data_out = '0; bus.dm_write_data = '0; bus.rd_in = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        // reset values
        rst = 1'b1;
        repeat (3) cycle();
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_wb_data", bus.wb_data, 64'd0);
        check("rst_wb_exc", 64'(bus.wb_exc), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_mem_be", 64'(bus.mem_be), 64'd0);
        check("rst_ex_ready", 64'(bus.ex_ready), 64'd0);
        rst = 1'b0;
        cycle();

        // bypass
        r0 = req_cyc_cnt;
        exp_wb(64'h1234, 5'd5, 1'b0, 2'd0);
        issue(1'b0, 1'b0, 3'b011, 64'h1234, 64'h0, 5'd5);
        check_lat("bypass_lat", 0);
        cycle();
        check("bypass_pulse_end", 64'(bus.wb_valid), 64'd0);
        check("bypass_no_req", 64'(req_cyc_cnt - r0), 64'd0);

        // LB / LBU at 0x1003, same-cycle grant, response one cycle later
        rsp_gnt_wait = 0; rsp_rv_dly = 1; rsp_rdata = 64'h1122_3344_8055_6677;
        exp_req(64'h1000, 8'h08, 1'b0, 64'h0);
        exp_wb(64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b0, 2'd0);
        issue(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd7);
        wait_done(20);
        check_lat("lb_lat", 2);
        exp_req(64'h1000, 8'h08, 1'b0, 64'h0);
        exp_wb(64'h80, 5'd8, 1'b0, 2'd0);
        issue(1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 5'd8);
        wait_done(20);

        // SH at 0x6
        exp_req(64'h0, 8'hC0, 1'b1, 64'hABCD_0000_0000_0000);
        exp_wb(64'h0, 5'd9, 1'b0, 2'd0);
        issue(1'b0, 1'b1, 3'b001, 64'h6, 64'hABCD, 5'd9);
        wait_done(20);

        // delayed grant and response, then a stray response in IDLE
        rsp_gnt_wait = 2; rsp_rv_dly = 2; rsp_rdata = 64'h8765_4321_0FED_CBA9;
        exp_req(64'h40, 8'hFF, 1'b0, 64'h0);
        exp_wb(64'h8765_4321_0FED_CBA9, 5'd10, 1'b0, 2'd0);
        r0 = req_cyc_cnt; w0 = wb_cnt; busy = 0; n = 0;
        issue(1'b1, 1'b0, 3'b011, 64'h40, 64'h0, 5'd10);
        while (wb_cnt == w0 && n < 20) begin
            if (bus.ex_ready !== 1'b0) busy++;
            cycle();
            n++;
        end
        check("slow_ex_ready_busy", 64'(busy), 64'd0);
        check("slow_req_cycles", 64'(req_cyc_cnt - r0), 64'd3);
        check("slow_ex_ready_at_wb", 64'(bus.ex_ready), 64'd1);
        check_lat("slow_lat", 5);
        repeat (3) cycle();
        check("slow_one_wb", 64'(wb_cnt - w0), 64'd1);
        w0 = wb_cnt;
        rsp_stray = 1'b1;
        repeat (3) cycle();
        check("stray_no_wb", 64'(wb_cnt - w0), 64'd0);
        check("stray_no_req", 64'(bus.mem_req), 64'd0);
        rsp_gnt_wait = 0; rsp_rv_dly = 1;

        // misaligned word access at 0x2
        rsp_rdata = 64'h0000_0000_F234_5678;
        r0 = req_cyc_cnt;
`ifdef LSU_ALIGN_CHECK_EN
        exp_wb(64'h0, 5'd3, 1'b1, 2'd1);
        issue(1'b1, 1'b0, 3'b010, 64'h2, 64'h0, 5'd3);
        check_lat("lw_mis_lat", 0);
        wait_done(10);
        exp_wb(64'h0, 5'd4, 1'b1, 2'd2);
        issue(1'b0, 1'b1, 3'b010, 64'h2, 64'h1122_3344, 5'd4);
        wait_done(10);
        check("mis_no_req", 64'(req_cyc_cnt - r0), 64'd0);
`else
        exp_req(64'h0, 8'h0F, 1'b0, 64'h0);
        exp_wb(64'hFFFF_FFFF_F234_5678, 5'd3, 1'b0, 2'd0);
        issue(1'b1, 1'b0, 3'b010, 64'h2, 64'h0, 5'd3);
        wait_done(20);
        check_lat("lw_round_lat", 2);
        exp_req(64'h0, 8'h0F, 1'b1, 64'h1122_3344);
        exp_wb(64'h0, 5'd4, 1'b0, 2'd0);
        issue(1'b0, 1'b1, 3'b010, 64'h2, 64'h1122_3344, 5'd4);
        wait_done(20);
`endif

        // illegal encodings and both enables
        r0 = req_cyc_cnt;
        exp_wb(64'h0, 5'd11, 1'b1, 2'd3);
        issue(1'b1, 1'b0, 3'b111, 64'h100, 64'h0, 5'd11);
        check_lat("illegal_lat", 0);
        wait_done(10);
        exp_wb(64'h0, 5'd12, 1'b1, 2'd3);
        issue(1'b0, 1'b1, 3'b100, 64'h100, 64'h55, 5'd12);
        wait_done(10);
        exp_wb(64'h0, 5'd13, 1'b1, 2'd3);
        issue(1'b1, 1'b1, 3'b000, 64'h100, 64'h55, 5'd13);
        wait_done(10);
        check("illegal_no_req", 64'(req_cyc_cnt - r0), 64'd0);

        // timeout with no grant
        rsp_never_gnt = 1'b1;
        r0 = req_cyc_cnt;
        exp_wb(64'h0, 5'd14, 1'b1, 2'd3);
        issue(1'b1, 1'b0, 3'b011, 64'h80, 64'h0, 5'd14);
        wait_done(20);
        check_lat("tmo_req_lat", 8);
        check("tmo_req_cycles", 64'(req_cyc_cnt - r0), 64'd8);
        check("tmo_mem_req_low", 64'(bus.mem_req), 64'd0);
        rsp_never_gnt = 1'b0;

        // response on the timeout cycle completes normally
        rsp_gnt_wait = 0; rsp_rv_dly = 7; rsp_rdata = 64'h0123_4567_89AB_CDEF;
        exp_req(64'h88, 8'hFF, 1'b0, 64'h0);
        exp_wb(64'h0123_4567_89AB_CDEF, 5'd15, 1'b0, 2'd0);
        issue(1'b1, 1'b0, 3'b011, 64'h88, 64'h0, 5'd15);
        wait_done(20);
        check_lat("tmo_edge_lat", 8);

        // response one cycle too late: timeout in RESP, late rvalid ignored
        rsp_rv_dly = 8;
        exp_req(64'h90, 8'hFF, 1'b0, 64'h0);
        exp_wb(64'h0, 5'd16, 1'b1, 2'd3);
        issue(1'b1, 1'b0, 3'b011, 64'h90, 64'h0, 5'd16);
        wait_done(20);
        check_lat("tmo_resp_lat", 8);
        repeat (2) cycle();

        // reset while waiting for the response
        rsp_rv_dly = 5;
        w0 = wb_cnt;
        exp_req(64'hA0, 8'hFF, 1'b0, 64'h0);
        issue(1'b1, 1'b0, 3'b011, 64'hA0, 64'h0, 5'd17);
        cycle();
        check("rst_resp_busy", 64'(bus.ex_ready), 64'd0);
        rst = 1'b1;
        cycle();
        check("rst_resp_mem_req", 64'(bus.mem_req), 64'd0);
        rst = 1'b0;
        cycle();
        check("rst_resp_ready", 64'(bus.ex_ready), 64'd1);
        repeat (6) cycle();
        check("rst_resp_no_wb", 64'(wb_cnt - w0), 64'd0);

        // randomized aligned traffic against the reference model
        for (int it = 0; it < 24; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            rsp_gnt_wait = $urandom_range(0, 2);
            rsp_rv_dly   = $urandom_range(1, 2);
            rsp_rdata    = {$urandom, $urandom};
            d            = {$urandom, $urandom};
            if (kind < 2) begin
                a = {$urandom, $urandom};
                exp_wb(a, 5'(it), 1'b0, 2'd0);
                issue(1'b0, 1'b0, 3'b000, a, d, 5'(it));
            end else if (kind < 7) begin
                f3 = 3'($urandom_range(0, 6));
                a  = {$urandom, $urandom} & ~64'((1 << f3[1:0]) - 1);
                exp_req({a[63:3], 3'b000}, be_model(f3, a[2:0]), 1'b0, 64'h0);
                exp_wb(load_model(f3, a[2:0], rsp_rdata), 5'(it), 1'b0, 2'd0);
                issue(1'b1, 1'b0, f3, a, d, 5'(it));
            end else begin
                f3 = 3'($urandom_range(0, 3));
                a  = {$urandom, $urandom} & ~64'((1 << f3[1:0]) - 1);
                exp_req({a[63:3], 3'b000}, be_model(f3, a[2:0]), 1'b1, d << (8 * int'(a[2:0])));
                exp_wb(64'h0, 5'(it), 1'b0, 2'd0);
                issue(1'b0, 1'b1, f3, a, d, 5'(it));
            end
            wait_done(20);
        end

        repeat (2) cycle();
        check("final_wb_queue", 64'(wb_q.size()), 64'd0);
        check("final_req_queue", 64'(req_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
